// File: rtl/axis_12to8_pack_tx_pkg.sv
// Shared types and widths for the 12-bit word to 8-bit AXI-stream packer.
// Phase encoding is shared with the mirror 8-to-12 unpack path.
package axis_pack_pkg;

  localparam int IW  = 12;
  localparam int OW  = 8;
  localparam int NIB = 4;

  // P0: take word A, P1: take word B, P2: flush high byte of B,
  // P1L: flush the lone nibble of an odd-length frame.
  typedef enum logic [1:0] {
    P0  = 2'd0,
    P1  = 2'd1,
    P2  = 2'd2,
    P1L = 2'd3
  } pack_phase_e;

  // One output beat as staged into the output register.
  typedef struct packed {
    logic [OW-1:0] data;
    logic          last;
    logic          user;
  } pack_beat_t;

  // True in the phases that consume an input word.
  function automatic logic phase_takes_word(input pack_phase_e ph);
    return (ph == P0) || (ph == P1);
  endfunction

endpackage

// File: rtl/axis_12to8_pack_tx_if.sv
// AXI-stream bundle shared by the pack (master) and unpack (slaver) sides.
// tkeep is one bit per byte of tdata.
interface axi_stream_inf #(
  parameter int DSIZE = 8,
  parameter int USIZE = 1
) (
  input logic aclk,
  input logic aresetn
);

  localparam int KSIZE = (DSIZE + 7) / 8;

  logic             tvalid;
  logic             tready;
  logic [DSIZE-1:0] tdata;
  logic             tlast;
  logic [USIZE-1:0] tuser;
  logic [KSIZE-1:0] tkeep;

  modport master (
    input  aclk,
    input  aresetn,
    input  tready,
    output tvalid,
    output tdata,
    output tlast,
    output tuser,
    output tkeep
  );

  modport slaver (
    input  aclk,
    input  aresetn,
    input  tvalid,
    input  tdata,
    input  tlast,
    input  tuser,
    input  tkeep,
    output tready
  );

endinterface

// File: rtl/axis_12to8_pack_tx_out_reg.sv
// Single-stage AXI-stream output register: loads a new beat whenever the
// slot is empty or being drained, otherwise holds its contents stable.
module axis_out_reg #(
  parameter int DW = 8,
  parameter int UW = 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic          load,
  input  logic [DW-1:0] load_data,
  input  logic          load_last,
  input  logic [UW-1:0] load_user,
  input  logic          tready,
  output logic          adv,
  output logic          tvalid,
  output logic [DW-1:0] tdata,
  output logic          tlast,
  output logic [UW-1:0] tuser
);

  logic          tvalid_reg;
  logic [DW-1:0] tdata_reg;
  logic          tlast_reg;
  logic [UW-1:0] tuser_reg;

  assign adv = !tvalid_reg || tready;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      tvalid_reg <= 1'b0;
      tdata_reg  <= '0;
      tlast_reg  <= 1'b0;
      tuser_reg  <= '0;
    end else if (adv) begin
      // Without a new beat the slot simply empties; payload is left as is.
      tvalid_reg <= load;
      if (load) begin
        tdata_reg <= load_data;
        tlast_reg <= load_last;
        tuser_reg <= load_user;
      end
    end
  end

  assign tvalid = tvalid_reg;
  assign tdata  = tdata_reg;
  assign tlast  = tlast_reg;
  assign tuser  = tuser_reg;

endmodule

// File: rtl/axis_12to8_pack_tx.sv
// Packs pairs of 12-bit words into three bytes (little-endian nibble order)
// onto an 8-bit AXI stream. Optional frame counter: AXIS_PACK_STAT_EN.
module axis_12to8_pack_tx
  import axis_pack_pkg::*;
#(
  parameter int CNT_W  = 16,
  parameter int SOF_EN = 1
) (
  input  logic          clock,
  input  logic          rst_n,
  input  logic [IW-1:0] idata,
  input  logic          ivalid,
  input  logic          ilast,
  output logic          iready,
  axi_stream_inf.master axis_out
`ifdef AXIS_PACK_STAT_EN
  ,
  output logic [CNT_W-1:0] frame_cnt
`endif
);

  pack_phase_e    phase_reg, phase_next;
  logic [NIB-1:0] nib_reg, nib_next;
  logic [OW-1:0]  hb_reg, hb_next;
  logic           lst_reg, lst_next;
  logic           sof_reg, sof_next;

  pack_beat_t     beat;
  logic           load;
  logic           adv;
  logic           accept;

  logic           out_valid;
  logic [OW-1:0]  out_data;
  logic           out_last;
  logic [0:0]     out_user;
  logic [0:0]     load_user;

  // Gated by rst_n so the port reads 0 while reset is held.
  assign iready = rst_n && adv && phase_takes_word(phase_reg);
  assign accept = ivalid && iready;

  always_comb begin
    phase_next = phase_reg;
    nib_next   = nib_reg;
    hb_next    = hb_reg;
    lst_next   = lst_reg;
    sof_next   = sof_reg;
    load       = 1'b0;
    beat       = '0;

    unique case (phase_reg)
      P0: begin
        if (accept) begin
          load       = 1'b1;
          beat.data  = idata[OW-1:0];
          beat.user  = sof_reg;
          nib_next   = idata[IW-1:OW];
          sof_next   = 1'b0;
          phase_next = ilast ? P1L : P1;
        end
      end
      P1: begin
        if (accept) begin
          load       = 1'b1;
          beat.data  = {idata[NIB-1:0], nib_reg};
          hb_next    = idata[IW-1:NIB];
          lst_next   = ilast;
          phase_next = P2;
        end
      end
      P2: begin
        if (adv) begin
          load       = 1'b1;
          beat.data  = hb_reg;
          beat.last  = lst_reg;
          sof_next   = sof_reg | lst_reg;
          phase_next = P0;
        end
      end
      P1L: begin
        if (adv) begin
          load       = 1'b1;
          beat.data  = {{(OW-NIB){1'b0}}, nib_reg};
          beat.last  = 1'b1;
          sof_next   = 1'b1;
          phase_next = P0;
        end
      end
      default: begin
        phase_next = P0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      phase_reg <= P0;
      nib_reg   <= '0;
      hb_reg    <= '0;
      lst_reg   <= 1'b0;
      sof_reg   <= 1'b1;
    end else begin
      phase_reg <= phase_next;
      nib_reg   <= nib_next;
      hb_reg    <= hb_next;
      lst_reg   <= lst_next;
      sof_reg   <= sof_next;
    end
  end

  assign load_user = (SOF_EN != 0) ? beat.user : 1'b0;

  axis_out_reg #(
    .DW (OW),
    .UW (1)
  ) u_out_reg (
    .clock     (clock),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (beat.data),
    .load_last (beat.last),
    .load_user (load_user),
    .tready    (axis_out.tready),
    .adv       (adv),
    .tvalid    (out_valid),
    .tdata     (out_data),
    .tlast     (out_last),
    .tuser     (out_user)
  );

  assign axis_out.tvalid = out_valid;
  assign axis_out.tdata  = out_data;
  assign axis_out.tlast  = out_last;
  assign axis_out.tuser  = out_user;
  assign axis_out.tkeep  = '1;

`ifdef AXIS_PACK_STAT_EN
  logic [CNT_W-1:0] frame_cnt_reg;

  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      frame_cnt_reg <= '0;
    end else if (out_valid && axis_out.tready && out_last) begin
      frame_cnt_reg <= frame_cnt_reg + 1'b1;
    end
  end

  assign frame_cnt = frame_cnt_reg;
`endif

endmodule
